number_rom_arbiter: RTL

- Shares the single-port, 1-cycle-latency synchronous number-glyph ROM between two requesters.
- Requester 1 is the VGA pixel pipeline: high priority, fixed latency. Requester 2 is a host/debug reader with a request/acknowledge handshake.
- The block converts (glyph, row, col) into a flat ROM address for a horizontal digit strip, issues the ROM access, and routes the returned word to the correct requester.
- It sits between the VGA counters/colour logic and the Numbers ROM.

---
 rtl/number_rom_arbiter_if.sv | 50 +++++
 rtl/number_rom_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/number_rom_arbiter_if.sv
// number_rom_arbiter_if: signals between the glyph ROM arbiter and its
// neighbours. These are the VGA pixel pipeline, the host/debug reader and
// the Numbers ROM.
//   vga_*  : VGA fetch request (req/glyph/row/col) and response (valid/pixel/drop)
//   host_* : host read request (req/glyph/row/col) and response (ack/rvalid/rdata/err)
//   rom_*  : ROM read port (en/addr out of the arbiter, data back into it)
// Modports: slave = arbiter side, master = environment side.
interface number_rom_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 11
);
  logic                  vga_req;
  logic [3:0]            vga_glyph;
  logic [7:0]            vga_row;
  logic [7:0]            vga_col;
  logic                  vga_valid;
  logic [DATA_WIDTH-1:0] vga_pixel;
  logic                  vga_drop;

  logic                  host_req;
  logic [3:0]            host_glyph;
  logic [7:0]            host_row;
  logic [7:0]            host_col;
  logic                  host_ack;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_err;

  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport slave (
    input  vga_req, vga_glyph, vga_row, vga_col,
    output vga_valid, vga_pixel, vga_drop,
    input  host_req, host_glyph, host_row, host_col,
    output host_ack, host_rvalid, host_rdata, host_err,
    output rom_en, rom_addr,
    input  rom_data
  );

  modport master (
    output vga_req, vga_glyph, vga_row, vga_col,
    input  vga_valid, vga_pixel, vga_drop,
    output host_req, host_glyph, host_row, host_col,
    input  host_ack, host_rvalid, host_rdata, host_err,
    input  rom_en, rom_addr,
    output rom_data
  );
endinterface

// File: rtl/number_rom_arbiter.sv
// number_rom_arbiter: shares the single-port, 1-cycle-latency number-glyph
// ROM between two requesters. The VGA pixel pipeline has fixed priority. The
// host/debug reader uses a req/ack handshake. (glyph,row,col) is flattened to
// row*ROW_STRIDE + glyph*GLYPH_W + col. Both requesters see a response two
// edges after their request is sampled.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - number_rom_arbiter_if.slave (VGA, host and ROM signal groups)
// Optional feature, macro STARVE_GUARD_EN: after STARVE_MAX consecutive lost
// cycles, a pending host request pre-empts VGA. The pre-empted VGA request
// gets a vga_drop pulse instead of vga_valid. Without the macro, vga_drop is 0.
module number_rom_arbiter #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned ROW_STRIDE = 62,
  parameter int unsigned GLYPH_W    = 6,
  parameter int unsigned GLYPH_H    = 8,
  parameter int unsigned NUM_GLYPHS = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  number_rom_arbiter_if.slave  bus
);

  // Elaboration-time parameter sanity
  if (NUM_GLYPHS * GLYPH_W > ROW_STRIDE) begin : g_bad_stride
    $error("NUM_GLYPHS*GLYPH_W exceeds ROW_STRIDE");
  end
  if (GLYPH_H * ROW_STRIDE > (2 ** ADDR_WIDTH)) begin : g_bad_height
    $error("GLYPH_H*ROW_STRIDE exceeds the ROM address space");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;

  logic                   rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;

  // In-flight tags: stage 1 (ROM reading) and stage 2 (ROM data available)
  logic                   s1_vga_q, s1_vga_d;
  logic                   s1_host_q, s1_host_d;
  logic                   s1_oor_q, s1_oor_d;
  logic                   s2_vga_q, s2_host_q, s2_oor_q;

  logic                   vga_valid_q, vga_valid_d;
  logic [DATA_WIDTH-1:0]  vga_pixel_q, vga_pixel_d;
  logic                   host_ack_q, host_ack_d;
  logic                   host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0]  host_rdata_q, host_rdata_d;
  logic                   host_err_q, host_err_d;

  logic                   host_win_c;
  logic                   vga_win_c;
  logic                   oor_c;
  logic [3:0]             sel_glyph_c;
  logic [7:0]             sel_row_c;
  logic [7:0]             sel_col_c;
  logic [ADDR_WIDTH-1:0]  addr_c;

`ifdef STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0]    starve_q, starve_d;
  logic                   s1_drop_q, s1_drop_d;
  logic                   s2_drop_q;
  logic                   vga_drop_q, vga_drop_d;
`endif

  // Arbitration and address generation for the access sampled this edge
  always_comb begin
    host_win_c = 1'b0;
    if (state_q == S_IDLE && bus.host_req) begin
`ifdef STARVE_GUARD_EN
      host_win_c = !bus.vga_req || (starve_q == STARVE_W'(STARVE_MAX));
`else
      host_win_c = !bus.vga_req;
`endif
    end
    vga_win_c = bus.vga_req && !host_win_c;

    sel_glyph_c = host_win_c ? bus.host_glyph : bus.vga_glyph;
    sel_row_c   = host_win_c ? bus.host_row   : bus.vga_row;
    sel_col_c   = host_win_c ? bus.host_col   : bus.vga_col;

    oor_c = (32'(sel_glyph_c) >= NUM_GLYPHS) ||
            (32'(sel_row_c)   >= GLYPH_H)    ||
            (32'(sel_col_c)   >= GLYPH_W);

    addr_c = ADDR_WIDTH'(sel_row_c)   * ADDR_WIDTH'(ROW_STRIDE) +
             ADDR_WIDTH'(sel_glyph_c) * ADDR_WIDTH'(GLYPH_W)    +
             ADDR_WIDTH'(sel_col_c);
  end

  // Next-state: ROM issue, tag pipe, response routing and host FSM
  always_comb begin
    state_d       = state_q;
    rom_en_d      = 1'b0;
    rom_addr_d    = rom_addr_q;
    s1_vga_d      = 1'b0;
    s1_host_d     = 1'b0;
    s1_oor_d      = 1'b0;
    vga_valid_d   = 1'b0;
    vga_pixel_d   = vga_pixel_q;
    host_ack_d    = 1'b0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_err_d    = host_err_q;
`ifdef STARVE_GUARD_EN
    starve_d      = starve_q;
    s1_drop_d     = 1'b0;
    vga_drop_d    = s2_drop_q;
`endif

    // An out-of-range request still consumes its slot but leaves the ROM idle
    if (host_win_c || vga_win_c) begin
      s1_vga_d  = vga_win_c;
      s1_host_d = host_win_c;
      s1_oor_d  = oor_c;
      if (!oor_c) begin
        rom_en_d   = 1'b1;
        rom_addr_d = addr_c;
      end
    end

    if (s2_vga_q) begin
      vga_valid_d = 1'b1;
      vga_pixel_d = s2_oor_q ? '0 : bus.rom_data;
    end

    case (state_q)
      S_IDLE: begin
        if (host_win_c) begin
          host_ack_d = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (s2_host_q) begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = s2_oor_q ? '0 : bus.rom_data;
          host_err_d    = s2_oor_q;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef STARVE_GUARD_EN
    // Counts cycles an idle-FSM host request lost its slot to VGA
    if (!bus.host_req || host_win_c) begin
      starve_d = '0;
    end else if (state_q == S_IDLE && bus.vga_req) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    s1_drop_d = bus.vga_req && host_win_c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rom_en_q      <= 1'b0;
      rom_addr_q    <= '0;
      s1_vga_q      <= 1'b0;
      s1_host_q     <= 1'b0;
      s1_oor_q      <= 1'b0;
      s2_vga_q      <= 1'b0;
      s2_host_q     <= 1'b0;
      s2_oor_q      <= 1'b0;
      vga_valid_q   <= 1'b0;
      vga_pixel_q   <= '0;
      host_ack_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_err_q    <= 1'b0;
`ifdef STARVE_GUARD_EN
      starve_q      <= '0;
      s1_drop_q     <= 1'b0;
      s2_drop_q     <= 1'b0;
      vga_drop_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rom_en_q      <= rom_en_d;
      rom_addr_q    <= rom_addr_d;
      s1_vga_q      <= s1_vga_d;
      s1_host_q     <= s1_host_d;
      s1_oor_q      <= s1_oor_d;
      s2_vga_q      <= s1_vga_q;
      s2_host_q     <= s1_host_q;
      s2_oor_q      <= s1_oor_q;
      vga_valid_q   <= vga_valid_d;
      vga_pixel_q   <= vga_pixel_d;
      host_ack_q    <= host_ack_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      host_err_q    <= host_err_d;
`ifdef STARVE_GUARD_EN
      starve_q      <= starve_d;
      s1_drop_q     <= s1_drop_d;
      s2_drop_q     <= s1_drop_q;
      vga_drop_q    <= vga_drop_d;
`endif
    end
  end

  assign bus.rom_en      = rom_en_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.vga_valid   = vga_valid_q;
  assign bus.vga_pixel   = vga_pixel_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_err    = host_err_q;
`ifdef STARVE_GUARD_EN
  assign bus.vga_drop    = vga_drop_q;
`else
  assign bus.vga_drop    = 1'b0;
`endif

endmodule
